// File: rtl/bullet_scheduler_pkg.sv
// Shared game package: default geometry/timing for the bullet pool and the scheduler FSM encoding.
package bullet_scheduler_pkg;

    localparam int DEF_NUM_SLOTS = 8;
    localparam int DEF_SPEED     = 4;
    localparam int DEF_COOLDOWN  = 6;
    localparam int DEF_BULLET_W  = 4;
    localparam int DEF_BULLET_H  = 8;
    localparam int COORD_W       = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_SPAWN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/bullet_scheduler_slot_hit.sv
// Box test for one bullet slot: hit when the pixel lies inside the live slot's box.
module bullet_slot_hit
    import bullet_scheduler_pkg::*;
#(
    parameter int BULLET_W = DEF_BULLET_W,
    parameter int BULLET_H = DEF_BULLET_H
) (
    input  logic               live_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] h_i,
    input  logic [COORD_W-1:0] v_i,
    output logic               hit_o
);

    // One extra bit so boxes near the right/bottom edge do not wrap.
    localparam logic [COORD_W:0] W_EXT = (COORD_W+1)'(BULLET_W);
    localparam logic [COORD_W:0] H_EXT = (COORD_W+1)'(BULLET_H);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    assign x_end = {1'b0, x_i} + W_EXT;
    assign y_end = {1'b0, y_i} + H_EXT;

    assign hit_o = live_i
                 && (h_i >= x_i) && ({1'b0, h_i} < x_end)
                 && (v_i >= y_i) && ({1'b0, v_i} < y_end);

endmodule

// File: rtl/bullet_scheduler.sv
// Bullet pool scheduler: per-frame sweep moves/frees slots, then optionally spawns one bullet.
// Define BULLET_SCHED_OVERRUN_EN to enable the sticky dropped-frame_tick flag on overrun.
//   state   | meaning
//   S_IDLE  | waiting for frame_tick
//   S_MOVE  | one slot per cycle: move up or free
//   S_SPAWN | write lowest free slot, pulse fire_ack
module bullet_scheduler
    import bullet_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int SPEED     = DEF_SPEED,
    parameter int COOLDOWN  = DEF_COOLDOWN,
    parameter int BULLET_W  = DEF_BULLET_W,
    parameter int BULLET_H  = DEF_BULLET_H
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_tick,
    input  logic                           shoot_req,
    input  logic [COORD_W-1:0]             spawn_x,
    input  logic [COORD_W-1:0]             spawn_y,
    input  logic [COORD_W-1:0]             h_cnt,
    input  logic [COORD_W-1:0]             v_cnt,
    output logic                           pix_hit,
    output logic                           fire_ack,
    output logic [$clog2(NUM_SLOTS+1)-1:0] live_cnt,
    output logic                           busy,
    output logic                           overrun
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(NUM_SLOTS+1);
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN+1) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_SLOTS-1);
    localparam logic [COORD_W-1:0] SPEED_C    = COORD_W'(SPEED);
    localparam logic [CD_W-1:0]    COOLDOWN_C = CD_W'(COOLDOWN);

    sched_state_e          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CD_W-1:0]       cd_q, cd_d;
    logic [NUM_SLOTS-1:0]  live_q, live_d, live_after;
    logic [COORD_W-1:0]    x_q [NUM_SLOTS];
    logic [COORD_W-1:0]    y_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  hit_vec;
    logic [CNT_W-1:0]      cnt_d, live_cnt_q;
    logic                  pix_hit_q;
    logic                  move_live, move_free, any_free;
    logic [IDX_W-1:0]      free_idx;

    assign move_live = (state_q == S_MOVE) && live_q[idx_q];
    assign move_free = move_live && (y_q[idx_q] < SPEED_C);

    always_comb begin
        live_after = live_q;
        if (move_free) live_after[idx_q] = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS-1; i >= 0; i--) begin
            if (!live_q[i]) free_idx = IDX_W'(i);
        end
        live_d = live_after;
        if (state_q == S_SPAWN) live_d[free_idx] = 1'b1;
    end

    // Free-slot check includes a slot freed on the final MOVE cycle.
    assign any_free = ~&live_after;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cd_d     = cd_q;
        fire_ack = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    state_d = S_MOVE;
                    idx_d   = '0;
                    cd_d    = (cd_q != '0) ? cd_q - CD_W'(1) : cd_q;
                end
            end
            S_MOVE: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = (shoot_req && (cd_q == '0) && any_free) ? S_SPAWN : S_IDLE;
                end
            end
            S_SPAWN: begin
                fire_ack = 1'b1;
                cd_d     = COOLDOWN_C;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt_d = cnt_d + CNT_W'(live_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cd_q       <= '0;
            live_q     <= '0;
            live_cnt_q <= '0;
            pix_hit_q  <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cd_q       <= cd_d;
            live_q     <= live_d;
            live_cnt_q <= cnt_d;
            pix_hit_q  <= |hit_vec;
            if (move_live && !move_free) y_q[idx_q] <= y_q[idx_q] - SPEED_C;
            if (state_q == S_SPAWN) begin
                x_q[free_idx] <= spawn_x;
                y_q[free_idx] <= spawn_y;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
        bullet_slot_hit #(
            .BULLET_W (BULLET_W),
            .BULLET_H (BULLET_H)
        ) u_hit (
            .live_i (live_q[g]),
            .x_i    (x_q[g]),
            .y_i    (y_q[g]),
            .h_i    (h_cnt),
            .v_i    (v_cnt),
            .hit_o  (hit_vec[g])
        );
    end

`ifdef BULLET_SCHED_OVERRUN_EN
    logic overrun_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else if (frame_tick && (state_q != S_IDLE)) begin
            overrun_q <= 1'b1;
        end
    end
    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign busy     = (state_q != S_IDLE);
    assign pix_hit  = pix_hit_q;
    assign live_cnt = live_cnt_q;

endmodule

// File: doc/bullet_scheduler.md
BULLET_SCHEDULER -- requirements
Module: bullet_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_SLOTS, default 8, meaning the number of bullet slots in the pool.
REQ-002 The block SHALL have parameter SPEED, default 4, meaning the pixels a bullet moves up per frame.
REQ-003 The block SHALL have parameter COOLDOWN, default 6, meaning the frames between accepted shots.
REQ-004 The block SHALL have parameters BULLET_W, default 4, and BULLET_H, default 8, meaning the bullet box size in pixels.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 The block SHALL have port frame_tick, input, 1 bit: a one-cycle pulse once per frame.
REQ-008 The block SHALL have port shoot_req, input, 1 bit: level, the player fire request.
REQ-009 The block SHALL have ports spawn_x and spawn_y, input, 10 bits each: the spawn position (player muzzle).
REQ-010 The block SHALL have ports h_cnt and v_cnt, input, 10 bits each: the current pixel coordinate.
REQ-011 The block SHALL have port pix_hit, output, 1 bit: the pixel lies inside a live bullet.
REQ-012 The block SHALL have port fire_ack, output, 1 bit: a one-cycle pulse when a bullet is spawned.
REQ-013 The block SHALL have port live_cnt, output, $clog2(NUM_SLOTS+1) bits: the number of live slots.
REQ-014 The block SHALL have port busy, output, 1 bit: high while the FSM is not in IDLE.
REQ-015 The block SHALL have port overrun, output, 1 bit: a sticky flag set by a frame_tick that is dropped (see REQ-029).

Function
REQ-016 Each slot SHALL hold live (1 bit), x (10 bits) and y (10 bits).
REQ-017 The FSM SHALL have states IDLE, MOVE and SPAWN.
REQ-018 IDLE SHALL go to MOVE on frame_tick, with the slot index set to 0.
REQ-019 MOVE SHALL process one slot per cycle, index 0 to NUM_SLOTS-1.
- Live slot with y >= SPEED: y SHALL become y - SPEED.
- Live slot with y < SPEED: live SHALL clear (freed); there is no wrap-around.
REQ-020 After the last slot, MOVE SHALL go to SPAWN if shoot_req=1, cooldown=0 and at least one slot is free (evaluated after the frees of this sweep); otherwise it SHALL go to IDLE.
REQ-021 SPAWN SHALL write the lowest-index free slot with live=1, x=spawn_x, y=spawn_y, pulse fire_ack, reload cooldown to COOLDOWN, and return to IDLE in 1 cycle.
REQ-022 The cooldown counter SHALL decrement by 1 on each accepted frame_tick, saturating at 0, and SHALL be reloaded only in SPAWN.
REQ-023 When the pool is full, the request SHALL be ignored: no fire_ack and no cooldown reload.
REQ-024 Frame latency SHALL be exactly NUM_SLOTS+1 cycles from frame_tick to IDLE, or NUM_SLOTS+2 with SPAWN.
REQ-025 pix_hit SHALL be registered with 1-cycle latency, and SHALL be 1 if any live slot has x <= h_cnt < x+BULLET_W and y <= v_cnt < y+BULLET_H.
REQ-026 Box bounds SHALL be computed at 11 bits so that x+BULLET_W and y+BULLET_H do not overflow.
REQ-027 live_cnt SHALL be registered and updated in the cycle after any live change.
REQ-028 pix_hit SHALL reflect slot contents mid-sweep; the sweep is intended to run during vertical blank.
REQ-029 A frame_tick while busy=1 SHALL be dropped and SHALL set overrun.

Reset
REQ-030 On rst low, all slots SHALL have live=0, x=0 and y=0.
REQ-031 On rst low, cooldown SHALL be 0, the FSM SHALL be in IDLE, and pix_hit, fire_ack, live_cnt, busy and overrun SHALL be 0.
REQ-032 Reset mid-sweep SHALL abort immediately; the first frame_tick after release SHALL start a clean sweep.

Configuration
REQ-033 With macro BULLET_SCHED_OVERRUN_EN defined, overrun SHALL be the sticky flag, cleared only by reset.
REQ-034 Without BULLET_SCHED_OVERRUN_EN, overrun SHALL be tied to 0 and the dropped-tick detection logic SHALL be absent; frame_tick while busy is still ignored.

Structure
REQ-035 The FSM state encoding and the default values of NUM_SLOTS, SPEED, COOLDOWN, BULLET_W and BULLET_H SHALL live in the shared game package.
REQ-036 The per-slot box comparison SHALL be a sub-module, bullet_slot_hit, instantiated NUM_SLOTS times and OR-reduced into pix_hit.

Verification
REQ-037 Test: shoot_req=1, spawn=(100,400), one frame_tick -> fire_ack at cycle NUM_SLOTS+1 after the tick; slot0=(100,400); live_cnt=1.
REQ-038 Test: after REQ-037, two more frame_ticks with shoot_req=1 -> slot0 y=396, then 392; no new spawn until the 6th frame after the shot (cooldown).
REQ-039 Test: bullet at y=3 with SPEED=4, one frame_tick -> slot freed, live_cnt decrements, no wrap to 1023.
REQ-040 Test: all 8 slots live with shoot_req=1 -> no fire_ack, cooldown unchanged; after one slot is freed in a sweep, spawn occurs in that same frame into the lowest free index.
REQ-041 Test: slot at (100,200), h/v scanned over (99..104, 199..208) -> pix_hit=1 exactly for h 100..103 and v 200..207, one cycle late.
REQ-042 Test: frame_tick pulsed mid-sweep, and rst low mid-sweep -> overrun=1 with the macro (0 without); after reset, all outputs are 0 and the next tick sweeps cleanly.
